// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin arbiter for the two ports that share the program
// ROM read path (instruction fetch and data load). It grants at most one request
// per cycle, drives the ROM address and size, and captures the ROM data into a
// response slot for each port. Each slot has a valid/ready handshake. Misaligned
// and out-of-range requests return err=1 with zero data.
module rom_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int ROM_WORDS = 256
) (
  input  logic              clk_i,
  input  logic              rst_ni,

  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic [1:0]        if_hb_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  input  logic              if_rready_i,
  output logic [31:0]       if_rdata_o,
  output logic              if_err_o,

  input  logic              ld_req_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [1:0]        ld_hb_i,
  output logic              ld_gnt_o,
  output logic              ld_rvalid_o,
  input  logic              ld_rready_i,
  output logic [31:0]       ld_rdata_o,
  output logic              ld_err_o,

  output logic [ADDR_W-1:0] rom_addr_o,
  output logic [1:0]        rom_hb_o,
  input  logic [31:0]       rom_rdata_i
);

  // Remembers which port won the last grant, so the other port wins the next tie.
  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_LD = 1'b1
  } port_e;

  // First word index that is beyond the end of the ROM, at address width.
  localparam logic [ADDR_W-1:0] ROM_LIMIT = ADDR_W'(ROM_WORDS);

  port_e last_q;

  logic        if_rvalid_q;
  logic [31:0] if_rdata_q;
  logic        if_err_q;

  logic        ld_rvalid_q;
  logic [31:0] ld_rdata_q;
  logic        ld_err_q;

  logic if_elig;
  logic ld_elig;
  logic if_gnt;
  logic ld_gnt;

  logic              misaligned;
  logic              out_of_range;
  logic              req_err;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       cap_data;

  // Byte accesses are never misaligned. A half access needs an even address.
  // A word access needs address bits [1:0] to be zero.
  function automatic logic is_misaligned(input logic [1:0] hb, input logic [1:0] lsb);
    logic bad;
    bad = 1'b0;
    if (hb == 2'b01) begin
      bad = lsb[0];
    end else if (hb[1]) begin
      bad = (lsb != 2'b00);
    end
    return bad;
  endfunction

  // A port is eligible when it requests and its slot is free or is draining this cycle.
  // On a tie, the port not named by last_q wins.
  always_comb begin
    if_elig = if_req_i && (!if_rvalid_q || if_rready_i);
    ld_elig = ld_req_i && (!ld_rvalid_q || ld_rready_i);
    if_gnt  = if_elig && (!ld_elig || (last_q == PORT_LD));
    ld_gnt  = ld_elig && (!if_elig || (last_q == PORT_IF));
  end

  // The granted port's request goes to the ROM. With no grant the ROM sees zero.
  always_comb begin
    rom_addr_o = '0;
    rom_hb_o   = 2'b00;
    if (if_gnt) begin
      rom_addr_o = if_addr_i;
      rom_hb_o   = if_hb_i;
    end else if (ld_gnt) begin
      rom_addr_o = ld_addr_i;
      rom_hb_o   = ld_hb_i;
    end
  end

  // Classify the granted request. An error response carries zero data, not ROM contents.
  always_comb begin
    word_idx     = {2'b00, rom_addr_o[ADDR_W-1:2]};
    misaligned   = is_misaligned(rom_hb_o, rom_addr_o[1:0]);
    out_of_range = (word_idx >= ROM_LIMIT);
    req_err      = misaligned || out_of_range;
    cap_data     = req_err ? 32'h0 : rom_rdata_i;
  end

  // Record the winner of each grant. The reset value LD makes IF win the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= PORT_LD;
    end else if (if_gnt) begin
      last_q <= PORT_IF;
    end else if (ld_gnt) begin
      last_q <= PORT_LD;
    end
  end

  // IF response slot. A new grant overwrites the slot while it drains, so there is no bubble.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= 32'h0;
      if_err_q    <= 1'b0;
    end else if (if_gnt) begin
      if_rvalid_q <= 1'b1;
      if_rdata_q  <= cap_data;
      if_err_q    <= req_err;
    end else if (if_rvalid_q && if_rready_i) begin
      if_rvalid_q <= 1'b0;
    end
  end

  // LD response slot. It behaves the same way as the IF slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ld_rvalid_q <= 1'b0;
      ld_rdata_q  <= 32'h0;
      ld_err_q    <= 1'b0;
    end else if (ld_gnt) begin
      ld_rvalid_q <= 1'b1;
      ld_rdata_q  <= cap_data;
      ld_err_q    <= req_err;
    end else if (ld_rvalid_q && ld_rready_i) begin
      ld_rvalid_q <= 1'b0;
    end
  end

  assign if_gnt_o    = if_gnt;
  assign if_rvalid_o = if_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign if_err_o    = if_err_q;

  assign ld_gnt_o    = ld_gnt;
  assign ld_rvalid_o = ld_rvalid_q;
  assign ld_rdata_o  = ld_rdata_q;
  assign ld_err_o    = ld_err_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed scoreboard bench for rom_arbiter.
// The stimulus checks the grants and the ROM drive, and queues the expected responses.
// The monitor pops an expected response on each accepted response and compares it.
module tb_rom_arbiter;

  localparam int ADDR_W    = 32;
  localparam int ROM_WORDS = 256;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              if_req_i, if_gnt_o, if_rvalid_o, if_rready_i, if_err_o;
  logic [ADDR_W-1:0] if_addr_i;
  logic [1:0]        if_hb_i;
  logic [31:0]       if_rdata_o;
  logic              ld_req_i, ld_gnt_o, ld_rvalid_o, ld_rready_i, ld_err_o;
  logic [ADDR_W-1:0] ld_addr_i;
  logic [1:0]        ld_hb_i;
  logic [31:0]       ld_rdata_o;
  logic [ADDR_W-1:0] rom_addr_o;
  logic [1:0]        rom_hb_o;
  logic [31:0]       rom_rdata_i;

  logic [31:0] rom_mem [0:ROM_WORDS-1];
  logic [31:0] romWord;
  logic [32:0] ifExp[$];
  logic [32:0] ldExp[$];
  logic [32:0] monExp;
  int          checks   = 0;
  int          failures = 0;

  rom_arbiter #(.ADDR_W(ADDR_W), .ROM_WORDS(ROM_WORDS)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_hb_i(if_hb_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rready_i(if_rready_i), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
    .ld_req_i(ld_req_i), .ld_addr_i(ld_addr_i), .ld_hb_i(ld_hb_i), .ld_gnt_o(ld_gnt_o),
    .ld_rvalid_o(ld_rvalid_o), .ld_rready_i(ld_rready_i), .ld_rdata_o(ld_rdata_o), .ld_err_o(ld_err_o),
    .rom_addr_o(rom_addr_o), .rom_hb_o(rom_hb_o), .rom_rdata_i(rom_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Combinational ROM: zero-extended byte, half or word. Out of range returns junk.
  always_comb begin
    romWord = 32'hDEADBEEF;
    if (rom_addr_o[31:2] < 30'(ROM_WORDS)) romWord = rom_mem[rom_addr_o[9:2]];
    case (rom_hb_o)
      2'b00:   rom_rdata_i = {24'h0, 8'(romWord >> {rom_addr_o[1:0], 3'b000})};
      2'b01:   rom_rdata_i = {16'h0, 16'(romWord >> {rom_addr_o[1], 4'b0000})};
      default: rom_rdata_i = romWord;
    endcase
  end

  task automatic checkOutput(input string name, input logic [32:0] actual, input logic [32:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: each accepted response must match the oldest expected response for that port.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (if_rvalid_o && if_rready_i) begin
        if (ifExp.size() == 0) begin
          checks++; failures++;
          $display("[TB] FAIL if_unexpected_rsp: got response 0x%0h, expected none", if_rdata_o);
        end else begin
          monExp = ifExp.pop_front();
          checkOutput("if_rdata", {1'b0, if_rdata_o}, {1'b0, monExp[31:0]});
          checkOutput("if_err", {32'h0, if_err_o}, {32'h0, monExp[32]});
        end
      end
      if (ld_rvalid_o && ld_rready_i) begin
        if (ldExp.size() == 0) begin
          checks++; failures++;
          $display("[TB] FAIL ld_unexpected_rsp: got response 0x%0h, expected none", ld_rdata_o);
        end else begin
          monExp = ldExp.pop_front();
          checkOutput("ld_rdata", {1'b0, ld_rdata_o}, {1'b0, monExp[31:0]});
          checkOutput("ld_err", {32'h0, ld_err_o}, {32'h0, monExp[32]});
        end
      end
    end
  end

  // Drive one cycle, then check the grants and the ROM drive against the given
  // values. If a grant is expected, queue the expected response for that port.
  task automatic applyStimulus(
    input logic ir, input logic [31:0] ia, input logic [1:0] ih, input logic irr,
    input logic lr, input logic [31:0] la, input logic [1:0] lh, input logic lrr,
    input logic eIfGnt, input logic eLdGnt, input logic [31:0] eAddr,
    input logic [31:0] eData, input logic eErr,
    input logic holdEn, input logic [31:0] holdData);
    logic [1:0] eHb;
    if_req_i = ir; if_addr_i = ia; if_hb_i = ih; if_rready_i = irr;
    ld_req_i = lr; ld_addr_i = la; ld_hb_i = lh; ld_rready_i = lrr;
    eHb = eIfGnt ? ih : (eLdGnt ? lh : 2'b00);
    @(negedge clk_i);
    checkOutput("if_gnt", {32'h0, if_gnt_o}, {32'h0, eIfGnt});
    checkOutput("ld_gnt", {32'h0, ld_gnt_o}, {32'h0, eLdGnt});
    checkOutput("rom_addr", {1'b0, rom_addr_o}, {1'b0, eAddr});
    checkOutput("rom_hb", {31'h0, rom_hb_o}, {31'h0, eHb});
    if (holdEn) begin
      checkOutput("if_hold_valid", {32'h0, if_rvalid_o}, 33'h1);
      checkOutput("if_hold_rdata", {1'b0, if_rdata_o}, {1'b0, holdData});
    end
    if (eIfGnt) ifExp.push_back({eErr, eData});
    if (eLdGnt) ldExp.push_back({eErr, eData});
    @(posedge clk_i);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(0, 32'h0, 2'b00, 1, 0, 32'h0, 2'b00, 1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_if_rvalid", {32'h0, if_rvalid_o}, 33'h0);
    checkOutput("rst_ld_rvalid", {32'h0, ld_rvalid_o}, 33'h0);
    checkOutput("rst_if_rdata", {1'b0, if_rdata_o}, 33'h0);
    checkOutput("rst_ld_rdata", {1'b0, ld_rdata_o}, 33'h0);
    checkOutput("rst_if_err", {32'h0, if_err_o}, 33'h0);
    checkOutput("rst_ld_err", {32'h0, ld_err_o}, 33'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < ROM_WORDS; i++) rom_mem[i] = 32'h0;
    rom_mem[0]   = 32'h11223344;
    rom_mem[1]   = 32'hAABBCCDD;
    rom_mem[2]   = 32'h55667788;
    rom_mem[3]   = 32'h0BADF00D;
    rom_mem[4]   = 32'hCAFEBABE;
    rom_mem[5]   = 32'h13579BDF;
    rom_mem[255] = 32'hFEEDFACE;

    rst_ni = 1'b0;
    if_req_i = 0; if_addr_i = '0; if_hb_i = 2'b00; if_rready_i = 0;
    ld_req_i = 0; ld_addr_i = '0; ld_hb_i = 2'b00; ld_rready_i = 0;
    @(posedge clk_i); @(posedge clk_i); #1;
    checkResetOutputs();
    checkOutput("rst_if_gnt", {32'h0, if_gnt_o}, 33'h0);
    checkOutput("rst_ld_gnt", {32'h0, ld_gnt_o}, 33'h0);
    rst_ni = 1'b1;

    // Both ports request continuously: the grants alternate, starting with IF.
    applyStimulus(1, 32'h4, 2'b10, 1, 1, 32'h8, 2'b10, 1, 1, 0, 32'h4, 32'hAABBCCDD, 0, 0, 32'h0);
    applyStimulus(1, 32'h4, 2'b10, 1, 1, 32'h8, 2'b10, 1, 0, 1, 32'h8, 32'h55667788, 0, 0, 32'h0);
    applyStimulus(1, 32'h4, 2'b10, 1, 1, 32'h8, 2'b10, 1, 1, 0, 32'h4, 32'hAABBCCDD, 0, 0, 32'h0);
    applyStimulus(1, 32'h4, 2'b10, 1, 1, 32'h8, 2'b10, 1, 0, 1, 32'h8, 32'h55667788, 0, 0, 32'h0);
    idleCycle();

    // IF word read at address 0.
    applyStimulus(1, 32'h0, 2'b10, 1, 0, 32'h0, 2'b00, 1, 1, 0, 32'h0, 32'h11223344, 0, 0, 32'h0);
    // LD byte and half reads are zero-extended.
    applyStimulus(0, 32'h0, 2'b00, 1, 1, 32'h3, 2'b00, 1, 0, 1, 32'h3, 32'h00000011, 0, 0, 32'h0);
    applyStimulus(0, 32'h0, 2'b00, 1, 1, 32'h2, 2'b01, 1, 0, 1, 32'h2, 32'h00001122, 0, 0, 32'h0);
    // Error cases: misaligned half, misaligned word, first out-of-range word.
    applyStimulus(0, 32'h0, 2'b00, 1, 1, 32'h1, 2'b01, 1, 0, 1, 32'h1, 32'h0, 1, 0, 32'h0);
    applyStimulus(0, 32'h0, 2'b00, 1, 1, 32'h6, 2'b11, 1, 0, 1, 32'h6, 32'h0, 1, 0, 32'h0);
    applyStimulus(0, 32'h0, 2'b00, 1, 1, 32'h400, 2'b10, 1, 0, 1, 32'h400, 32'h0, 1, 0, 32'h0);
    // The last ROM word is in range. A byte read at an odd address is not an error.
    applyStimulus(0, 32'h0, 2'b00, 1, 1, 32'h3FC, 2'b10, 1, 0, 1, 32'h3FC, 32'hFEEDFACE, 0, 0, 32'h0);
    applyStimulus(1, 32'h7, 2'b00, 1, 0, 32'h0, 2'b00, 1, 1, 0, 32'h7, 32'h000000AA, 0, 0, 32'h0);
    idleCycle();

    // Stalled IF response: LD is granted every cycle while if_rdata_o holds its value.
    applyStimulus(1, 32'hC, 2'b10, 1, 0, 32'h0, 2'b00, 1, 1, 0, 32'hC, 32'h0BADF00D, 0, 0, 32'h0);
    for (int s = 0; s < 3; s++)
      applyStimulus(1, 32'h10, 2'b10, 0, 1, 32'h14, 2'b10, 1, 0, 1, 32'h14, 32'h13579BDF, 0, 1, 32'h0BADF00D);
    applyStimulus(1, 32'h10, 2'b10, 1, 1, 32'h14, 2'b10, 1, 1, 0, 32'h10, 32'hCAFEBABE, 0, 1, 32'h0BADF00D);
    applyStimulus(0, 32'h0, 2'b00, 1, 0, 32'h0, 2'b00, 1, 0, 0, 32'h0, 32'h0, 0, 1, 32'hCAFEBABE);

    // Fill both slots, then reset in the middle of operation.
    applyStimulus(1, 32'h0, 2'b10, 0, 1, 32'h4, 2'b10, 0, 0, 1, 32'h4, 32'hAABBCCDD, 0, 0, 32'h0);
    applyStimulus(1, 32'h0, 2'b10, 0, 1, 32'h4, 2'b10, 0, 1, 0, 32'h0, 32'h11223344, 0, 0, 32'h0);
    checkOutput("pre_rst_if_rvalid", {32'h0, if_rvalid_o}, 33'h1);
    checkOutput("pre_rst_ld_rvalid", {32'h0, ld_rvalid_o}, 33'h1);
    rst_ni = 1'b0;
    #1;
    checkResetOutputs();
    ifExp.delete();
    ldExp.delete();
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_ni = 1'b1;
    // After reset, IF wins the first tie.
    applyStimulus(1, 32'h4, 2'b10, 1, 1, 32'h8, 2'b10, 1, 1, 0, 32'h4, 32'hAABBCCDD, 0, 0, 32'h0);
    idleCycle();
    idleCycle();

    checkOutput("if_queue_drained", 33'(ifExp.size()), 33'h0);
    checkOutput("ld_queue_drained", 33'(ldExp.size()), 33'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Two-port arbiter and response buffer in front of the shared program ROM. The instruction-fetch port and the data-load port both need the single combinational ROM read path. This block grants one request per cycle with round-robin priority, drives the ROM address and size, and captures the returned data into a per-port response register with a valid/ready handshake. It also flags misaligned and out-of-range accesses so they never reach the core as silent data.

## Interface
Parameters:
- ADDR_W, 32, byte-address width of both requesters and the ROM port.
- ROM_WORDS, 256, ROM depth in 32-bit words; word index at or above this value is out of range.

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- if_req_i  in  1  instruction-fetch request.
- if_addr_i  in  ADDR_W  fetch byte address.
- if_hb_i  in  2  fetch size (00 byte, 01 half, 1x word).
- if_gnt_o  out  1  fetch request accepted this cycle (combinational).
- if_rvalid_o  out  1  fetch response valid.
- if_rready_i  in  1  fetch response consumed.
- if_rdata_o  out  32  fetch response data.
- if_err_o  out  1  fetch response is an error.
- ld_*  same set as if_*, for the data-load port.
- rom_addr_o  out  ADDR_W  byte address to ROM.
- rom_hb_o  out  2  size to ROM.
- rom_rdata_i  in  32  combinational ROM read data (zero-extended by the ROM per size).

## Operation
- Eligibility: a port is eligible when req_i=1 and its slot is free or draining, i.e. !rvalid_q or rready_i.
- Arbitration:
  - One eligible port: that port is granted.
  - Both eligible: the port not named by last_q is granted.
  - last_q updates to the granted port on every grant.
  - last_q resets to LD, so IF wins the first tie.
- Exactly one gnt_o at most per cycle. gnt_o is never asserted to an ineligible port.
- ROM drive:
  - With a grant: rom_addr_o/rom_hb_o = the granted port's addr/hb.
  - Without a grant: rom_addr_o=0, rom_hb_o=00.
- Error check on the granted request:
  - Misaligned: hb=01 with addr[0]=1, or hb=1x with addr[1:0]≠00.
  - Out of range: addr[ADDR_W-1:2] ≥ ROM_WORDS.
  - Byte accesses are never misaligned.
- Response capture, on grant, into the granted port's slot:
  - rvalid_q←1.
  - rdata_q←(error ? 0 : rom_rdata_i).
  - err_q←error.
- Response drain: on rvalid&rready without a new grant to that port, rvalid_q←0. rdata_q and err_q hold their last values.
- Simultaneous drain and grant on the same port: the new response overwrites the slot, and rvalid stays 1. This gives back-to-back responses with no bubble.
- The ungranted port's slot is unaffected in any cycle.
- Response order per port equals grant order. Each grant produces exactly one response.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert use): if/ld_rvalid_o=0, rdata_o=0, err_o=0, last_q=LD. gnt_o is combinational and is 0 while slots are empty and no req.
- Latency: grant in cycle N, response visible (rvalid_o=1) from cycle N+1. It is held stable until the cycle in which rready_i=1.
- Throughput:
  - One grant per cycle total.
  - A single requesting port with rready tied high is granted every cycle.
  - Two continuously requesting ports alternate IF, LD, IF, …
- A stalled port (rvalid=1, rready=0) is not granted. The other port takes every cycle meanwhile.
- Reset asserted mid-operation: all pending responses are discarded immediately, and outputs take their reset values in the same instant.
- req_i may drop without a grant. No request state is stored before grant.

## Test plan
- ROM word0=0x11223344, IF word read addr 0x0, rready=1 → if_gnt_o=1 in cycle N; if_rvalid_o=1, if_rdata_o=0x11223344, err=0 in N+1.
- IF and LD both request word reads every cycle (addr 0x4, 0x8), rready=1 → grants IF,LD,IF,LD from the first cycle after reset; rom_addr_o alternates 0x4/0x8.
- LD byte read addr 0x3, word0=0x11223344 → ld_rdata_o=0x00000011; LD half read addr 0x2 → 0x00001122.
- LD half addr 0x1, then word addr 0x6, then word addr 0x400 (ROM_WORDS=256) → three responses, each with err=1 and rdata=0.
- IF response held with if_rready_i=0 for 3 cycles while IF keeps requesting and LD requests → no if_gnt_o; LD granted each cycle; if_rdata_o stable; IF is granted in the cycle rready rises, and the new data appears the next cycle with no bubble.
- rst_ni pulsed low while both slots are valid → rvalid outputs go to 0 at once; after release, the first tie grants IF.
